// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and bit-period helper,
// common to uart_rx and uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Below this the half-bit start check has no room to land mid-bit.
    localparam int MIN_CLKS_PER_BIT = 4;

    // System clocks per line bit (truncating division).
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops
// reset to 1 so a reset never looks like a start edge.
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Retime d into the clk domain through two flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data (LSB first), optional even parity, 1 stop.
// Build option: define UART_RX_PARITY_EN to expect and check an even-parity
// bit between the last data bit and the stop bit.
module uart_rx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    import uart_pkg::*;

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(CPB - 1);

    if (CPB < MIN_CLKS_PER_BIT) begin : g_cpb_check
        $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
    end

    uart_state_e   state, state_nxt;
    logic          rx_s;
    logic          rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bidx;
    logic [7:0]    sr;
    logic          expire;
    logic          par_bad;
    logic          ld_half, ld_full, do_shift;
    logic          set_valid, set_ferr, set_perr;
`ifdef UART_RX_PARITY_EN
    logic          par_bit;
    logic          do_par;
`endif

    uart_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign expire = (cnt == '0);
    assign busy   = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus parity bit must hold an even count of ones.
    assign par_bad = par_bit ^ (^sr);
`else
    assign par_bad = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state and per-cycle datapath controls.
    always_comb begin
        state_nxt = state;
        ld_half   = 1'b0;
        ld_full   = 1'b0;
        do_shift  = 1'b0;
        set_valid = 1'b0;
        set_ferr  = 1'b0;
        set_perr  = 1'b0;
`ifdef UART_RX_PARITY_EN
        do_par    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                // rx_prev low after a bad stop bit means the line has to go
                // high again before a falling edge can be seen (line break).
                if (rx_prev && !rx_s) begin
                    state_nxt = ST_START;
                    ld_half   = 1'b1;
                end
            end
            ST_START: begin
                if (expire) begin
                    if (rx_s) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_DATA;
                        ld_full   = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (expire) begin
                    do_shift = 1'b1;
                    ld_full  = 1'b1;
                    if (bidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (expire) begin
                    do_par    = 1'b1;
                    ld_full   = 1'b1;
                    state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Leave STOP on the sample itself so the next start edge
                // can be caught one cycle later.
                if (expire) begin
                    state_nxt = ST_IDLE;
                    if (!rx_s)        set_ferr  = 1'b1;
                    else if (par_bad) set_perr  = 1'b1;
                    else              set_valid = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bit-period counter: reloads only on explicit loads, parks at zero.
    always_ff @(posedge clk) begin
        if (rst)               cnt <= '0;
        else if (ld_half)      cnt <= HALF_RELOAD;
        else if (ld_full)      cnt <= FULL_RELOAD;
        else if (cnt != '0)    cnt <= cnt - 1'b1;
    end

    // Data bit index and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bidx <= 3'd0;
            sr   <= 8'h00;
        end else begin
            if (ld_half)       bidx <= 3'd0;
            else if (do_shift) bidx <= bidx + 3'd1;
            if (do_shift)      sr   <= {rx_s, sr[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Capture the received parity bit.
    always_ff @(posedge clk) begin
        if (rst)         par_bit <= 1'b0;
        else if (do_par) par_bit <= rx_s;
    end
`endif

    // Edge history and registered outputs; pulses land the cycle after the stop sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev   <= 1'b1;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_prev   <= rx_s;
            valid     <= set_valid;
            frame_err <= set_ferr;
            if (set_valid) data <= sr;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity error pulse.
    always_ff @(posedge clk) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= set_perr;
    end
`else
    assign parity_err = set_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx at 10 clocks per bit.
// Serial frames are built from bytes; expected outcomes are queued at
// issue time and consumed by a monitor whenever the DUT pulses an output.
module tb_uart_rx;

    localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid, frame_err, parity_err, busy;

    typedef struct {
        int         kind;   // 0 valid, 1 frame_err, 2 parity_err
        logic [7:0] d;      // data output expected alongside the pulse
    } exp_t;

    exp_t       sb[$];
    logic [7:0] last_good;
    int         n_chk  = 0;
    int         n_fail = 0;
    bit         prev_pulse = 1'b0;

    uart_rx #(.CLK_FREQ(100000000), .BAUD(10000000)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Called at each falling edge.
    task automatic monitor_step();
        int   npulse;
        int   kind;
        exp_t e;
        npulse = int'(valid) + int'(frame_err) + int'(parity_err);
        if (npulse != 0) begin
            chk("pulse_exclusive", npulse, 1);
            chk("pulse_one_cycle", prev_pulse, 0);
            kind = valid ? 0 : (frame_err ? 1 : 2);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: got kind %0d data %0h expected none", kind, data);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", kind, e.kind);
                chk("pulse_data", data, e.d);
            end
        end
        prev_pulse = (npulse != 0);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Queue the expected outcome, then serialise the frame and idle gap.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_ok, input int gap);
        exp_t e;
        logic par_bit;
        par_bit = par_ok ? ^d : ~(^d);
        if (!stop) begin
            e.kind = 1; e.d = last_good;
        end else if (PAR_EN && !par_ok) begin
            e.kind = 2; e.d = last_good;
        end else begin
            e.kind = 0; e.d = d; last_good = d;
        end
        sb.push_back(e);
        drive_bit(1'b0);
        chk("busy_in_frame", busy, 1);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(par_bit);
        drive_bit(stop);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int          k;
        logic [7:0]  d;
        bit          stop, pok;
        rst = 1'b1;
        rx  = 1'b1;
        last_good = 8'h00;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
            begin
                repeat (60000) @(negedge clk);
                $display("FAIL watchdog: simulation exceeded cycle budget");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Single clean frame
        send_frame(8'hD2, 1'b1, 1'b1, 20);

        // Short low glitch must be rejected without a pulse
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        chk("glitch_busy_rise", busy, 1);
        k = 0;
        while (busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("glitch_busy_drop", busy, 0);
        repeat (30) @(negedge clk);

        // Framing error then recovery
        send_frame(8'h5A, 1'b0, 1'b1, 20);
        send_frame(8'h3C, 1'b1, 1'b1, 20);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 1'b1, 20);

        // Reset in the middle of data bit 4 (bit 4 kept high so the line stays idle after)
        d = 8'($urandom) | 8'h10;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        chk("midrst_data", data, 8'h00);
        chk("midrst_busy", busy, 0);
        repeat (4 + 6 * CPB) @(negedge clk);
        send_frame(8'hA5, 1'b1, 1'b1, 20);

        // Parity bit wrong then right
        if (PAR_EN) begin
            send_frame(8'h07, 1'b1, 1'b0, 20);
            send_frame(8'h07, 1'b1, 1'b1, 20);
        end

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            pok  = ($urandom_range(0, 5) != 0);
            send_frame(d, stop, pok, stop ? int'($urandom_range(0, 15)) : int'($urandom_range(5, 15)));
        end

        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("final_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
